// File: rtl/app_stream_decoder.sv
// Application stream decoder: tags each flit with field type, task index and end-of-app.
// Latency 1 cycle via a single output register; credit_o drops while that register is held.
module app_stream_decoder #(
  parameter int FLIT_SIZE  = 32,
  parameter int MAX_TASKS  = 32,
  parameter int TASK_IDX_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  output logic                  credit_o,
  input  logic [FLIT_SIZE-1:0]  data_i,
  input  logic                  eoa_i,
  output logic                  field_valid_o,
  input  logic                  field_ready_i,
  output logic [3:0]            field_type_o,
  output logic [FLIT_SIZE-1:0]  field_data_o,
  output logic [TASK_IDX_W-1:0] task_idx_o,
  output logic                  field_last_o,
  output logic [15:0]           app_cnt_o,
  output logic                  all_done_o,
  output logic                  err_o
);

  // one extra bit so the task counter can hold MAX_TASKS itself
  localparam int CNT_W = TASK_IDX_W + 1;
  localparam logic [CNT_W-1:0]     MAX_CNT  = CNT_W'(MAX_TASKS);
  localparam logic [FLIT_SIZE-1:0] MAX_FLIT = FLIT_SIZE'(MAX_TASKS);

  typedef enum logic [3:0] {
    F_DSIZE = 4'd0, F_TCNT = 4'd1, F_MAP   = 4'd2, F_TAG = 4'd3, F_GRAPH = 4'd4,
    F_TEXT  = 4'd5, F_DATA = 4'd6, F_BSS   = 4'd7, F_ENTRY = 4'd8, F_BIN = 4'd9
  } field_e;

  typedef enum logic [3:0] {
    S_DSIZE, S_TCNT, S_MAP, S_TAG, S_GRAPH, S_TEXT, S_DATA, S_BSS, S_ENTRY, S_BIN
  } state_e;

  state_e                state_q, state_d;
  logic [FLIT_SIZE-1:0]  dsize_q, dsize_d;
  logic [FLIT_SIZE-1:0]  tcnt_q, tcnt_d;
  logic [FLIT_SIZE-1:0]  text_q, text_d;
  logic [FLIT_SIZE-1:0]  bin_q, bin_d;
  logic [FLIT_SIZE-1:0]  g_cnt_q, g_cnt_d;
  logic [FLIT_SIZE-1:0]  b_cnt_q, b_cnt_d;
  logic [CNT_W-1:0]      t_cnt_q, t_cnt_d;

  logic                  run_q;
  logic                  vld_q;
  field_e                type_q;
  logic [FLIT_SIZE-1:0]  data_q;
  logic [TASK_IDX_W-1:0] idx_q;
  logic                  last_q;
  logic [15:0]           app_cnt_q;
  logic                  done_q;
  logic                  err_q;

  logic                  acc;
  logic                  emit;
  logic                  app_end;
  logic                  task_end;
  logic                  err_set;
  logic                  done_set;
  field_e                f_type;
  logic [TASK_IDX_W-1:0] f_idx;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_new;
  logic [CNT_W-1:0]      t_inc;
  logic [FLIT_SIZE-1:0]  g_inc;
  logic [FLIT_SIZE-1:0]  b_inc;
  logic [FLIT_SIZE:0]    bin_sum;
  logic                  unused_bin_lsb;

  // run_q keeps credit low while reset is asserted
  assign credit_o = run_q && (!vld_q || field_ready_i);
  assign acc      = rx_i && credit_o;
  assign emit     = acc && !done_q;

  assign cnt     = (tcnt_q > MAX_FLIT) ? MAX_CNT : tcnt_q[CNT_W-1:0];
  assign cnt_new = (data_i > MAX_FLIT) ? MAX_CNT : data_i[CNT_W-1:0];
  assign t_inc   = t_cnt_q + CNT_W'(1);
  assign g_inc   = g_cnt_q + FLIT_SIZE'(1);
  assign b_inc   = b_cnt_q + FLIT_SIZE'(1);
  assign bin_sum = {1'b0, text_q} + {1'b0, data_i};
  assign unused_bin_lsb = ^bin_sum[1:0];

  always_comb begin
    state_d  = state_q;
    dsize_d  = dsize_q;
    tcnt_d   = tcnt_q;
    text_d   = text_q;
    bin_d    = bin_q;
    g_cnt_d  = g_cnt_q;
    b_cnt_d  = b_cnt_q;
    t_cnt_d  = t_cnt_q;
    f_type   = F_DSIZE;
    f_idx    = '0;
    app_end  = 1'b0;
    task_end = 1'b0;
    err_set  = 1'b0;
    done_set = 1'b0;

    if (eoa_i) begin
      if (state_q != S_DSIZE) err_set = 1'b1;
      else if (!vld_q)        done_set = 1'b1;
    end

    if (acc && done_q) begin
      err_set = 1'b1;
    end else if (acc) begin
      case (state_q)
        S_DSIZE: begin
          f_type  = F_DSIZE;
          dsize_d = data_i;
          state_d = S_TCNT;
        end
        S_TCNT: begin
          f_type  = F_TCNT;
          tcnt_d  = data_i;
          t_cnt_d = '0;
          g_cnt_d = '0;
          if (data_i > MAX_FLIT) err_set = 1'b1;
          if (cnt_new != '0)       state_d = S_MAP;
          else if (dsize_q != '0)  state_d = S_GRAPH;
          else                     app_end = 1'b1;
        end
        S_MAP: begin
          f_type  = F_MAP;
          f_idx   = t_cnt_q[TASK_IDX_W-1:0];
          state_d = S_TAG;
        end
        S_TAG: begin
          f_type  = F_TAG;
          f_idx   = t_cnt_q[TASK_IDX_W-1:0];
          t_cnt_d = t_inc;
          if (data_i != FLIT_SIZE'(1)) err_set = 1'b1;
          if (t_inc < cnt) begin
            state_d = S_MAP;
          end else if (dsize_q != '0) begin
            state_d = S_GRAPH;
          end else begin
            t_cnt_d = '0;
            state_d = S_TEXT;
          end
        end
        S_GRAPH: begin
          f_type  = F_GRAPH;
          g_cnt_d = g_inc;
          if (g_inc == dsize_q) begin
            if (cnt == '0) begin
              app_end = 1'b1;
            end else begin
              t_cnt_d = '0;
              state_d = S_TEXT;
            end
          end
        end
        S_TEXT: begin
          f_type  = F_TEXT;
          f_idx   = t_cnt_q[TASK_IDX_W-1:0];
          text_d  = data_i;
          state_d = S_DATA;
        end
        S_DATA: begin
          f_type  = F_DATA;
          f_idx   = t_cnt_q[TASK_IDX_W-1:0];
          bin_d   = {1'b0, bin_sum[FLIT_SIZE:2]};
          state_d = S_BSS;
        end
        S_BSS: begin
          f_type  = F_BSS;
          f_idx   = t_cnt_q[TASK_IDX_W-1:0];
          state_d = S_ENTRY;
        end
        S_ENTRY: begin
          f_type  = F_ENTRY;
          f_idx   = t_cnt_q[TASK_IDX_W-1:0];
          b_cnt_d = '0;
          if (bin_q == '0) task_end = 1'b1;
          else             state_d  = S_BIN;
        end
        S_BIN: begin
          f_type  = F_BIN;
          f_idx   = t_cnt_q[TASK_IDX_W-1:0];
          b_cnt_d = b_inc;
          if (b_inc == bin_q) task_end = 1'b1;
        end
        default: state_d = S_DSIZE;
      endcase

      if (task_end) begin
        t_cnt_d = t_inc;
        if (t_inc < cnt) state_d = S_TEXT;
        else             app_end = 1'b1;
      end
      if (app_end) state_d = S_DSIZE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_DSIZE;
      dsize_q   <= '0;
      tcnt_q    <= '0;
      text_q    <= '0;
      bin_q     <= '0;
      g_cnt_q   <= '0;
      b_cnt_q   <= '0;
      t_cnt_q   <= '0;
      run_q     <= 1'b0;
      app_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dsize_q   <= dsize_d;
      tcnt_q    <= tcnt_d;
      text_q    <= text_d;
      bin_q     <= bin_d;
      g_cnt_q   <= g_cnt_d;
      b_cnt_q   <= b_cnt_d;
      t_cnt_q   <= t_cnt_d;
      run_q     <= 1'b1;
      done_q    <= done_q | done_set;
      err_q     <= err_q | err_set;
      if (emit && app_end) app_cnt_q <= app_cnt_q + 16'd1;
    end
  end

  // a new flit overwrites the register in the same cycle the old one drains
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      type_q <= F_DSIZE;
      data_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else if (emit) begin
      vld_q  <= 1'b1;
      type_q <= f_type;
      data_q <= data_i;
      idx_q  <= f_idx;
      last_q <= app_end;
    end else if (field_ready_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign field_valid_o = vld_q;
  assign field_type_o  = type_q;
  assign field_data_o  = data_q;
  assign task_idx_o    = idx_q;
  assign field_last_o  = last_q;
  assign app_cnt_o     = app_cnt_q;
  assign all_done_o    = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_app_stream_decoder.sv
// Randomized bench: applications are generated as flit lists with their expected field
// tags, driven under random rx/ready patterns and compared in order at the output.
module tb_app_stream_decoder;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  ty;
    logic [4:0]  idx;
    logic        last;
  } fld_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rx_i;
  logic        credit_o;
  logic [31:0] data_i;
  logic        eoa_i;
  logic        field_valid_o;
  logic        field_ready_i;
  logic [3:0]  field_type_o;
  logic [31:0] field_data_o;
  logic [4:0]  task_idx_o;
  logic        field_last_o;
  logic [15:0] app_cnt_o;
  logic        all_done_o;
  logic        err_o;

  app_stream_decoder #(.FLIT_SIZE(32), .MAX_TASKS(32), .TASK_IDX_W(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .credit_o(credit_o), .data_i(data_i),
    .eoa_i(eoa_i), .field_valid_o(field_valid_o), .field_ready_i(field_ready_i),
    .field_type_o(field_type_o), .field_data_o(field_data_o), .task_idx_o(task_idx_o),
    .field_last_o(field_last_o), .app_cnt_o(app_cnt_o), .all_done_o(all_done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] tx_q[$];
  fld_t        exp_q[$];
  int          txt_a[8];
  int          dat_a[8];
  logic [15:0] app_exp;
  int          rdy_mode;
  bit          rx_full;
  bit          mon_en;
  bit          held;
  logic [31:0] held_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] ty, input logic [4:0] idx);
    fld_t e;
    e.d = d; e.ty = ty; e.idx = idx; e.last = 1'b0;
    tx_q.push_back(d);
    exp_q.push_back(e);
  endtask

  // Application layout straight from the protocol description; last flit gets the marker.
  task automatic gen_app(input int dsize, input int tcnt);
    fld_t e;
    push(32'(dsize), 4'd0, 5'd0);
    push(32'(tcnt), 4'd1, 5'd0);
    for (int t = 0; t < tcnt; t++) begin
      push(32'h0101 + 32'(t), 4'd2, 5'(t));
      push(32'd1, 4'd3, 5'(t));
    end
    for (int g = 0; g < dsize; g++) push(32'hA + 32'(g), 4'd4, 5'd0);
    for (int t = 0; t < tcnt; t++) begin
      push(32'(txt_a[t]), 4'd5, 5'(t));
      push(32'(dat_a[t]), 4'd6, 5'(t));
      push(32'(t * 16), 4'd7, 5'(t));
      push(32'h80 + 32'(t), 4'd8, 5'(t));
      for (int b = 0; b < (txt_a[t] + dat_a[t]) / 4; b++) push($urandom, 4'd9, 5'(t));
    end
    e = exp_q.pop_back();
    e.last = 1'b1;
    exp_q.push_back(e);
    app_exp++;
  endtask

  task automatic cycle();
    fld_t e;
    @(negedge clk_i);
    if (held) check("hold_data", field_data_o, held_d);
    case (rdy_mode)
      0:       field_ready_i = 1'b1;
      1:       field_ready_i = ~field_ready_i;
      default: field_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (tx_q.size() > 0 && (rx_full || $urandom_range(0, 3) != 0)) begin
      rx_i = 1'b1;
      data_i = tx_q[0];
    end else begin
      rx_i = 1'b0;
    end
    #1;
    if (field_valid_o && !field_ready_i) check("credit_hold", credit_o, 0);
    if (mon_en && field_valid_o && field_ready_i) begin
      if (exp_q.size() == 0) begin
        check("extra_field", field_valid_o, 0);
      end else begin
        e = exp_q.pop_front();
        check("type", field_type_o, e.ty);
        check("data", field_data_o, e.d);
        check("task_idx", task_idx_o, e.idx);
        check("last", field_last_o, e.last);
      end
    end
    if (rx_i && credit_o) tx_q.delete(0);
    held   = field_valid_o && !field_ready_i;
    held_d = field_data_o;
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && n < 4000) begin
      cycle();
      n++;
    end
    check("drain", tx_q.size() + exp_q.size(), 0);
    rdy_mode = 0;
    cycle();
    cycle();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    rx_i   = 1'b0;
    eoa_i  = 1'b0;
    #1;
    check("rst_credit", credit_o, 0);
    check("rst_valid", field_valid_o, 0);
    check("rst_type", field_type_o, 0);
    check("rst_data", field_data_o, 0);
    check("rst_idx", task_idx_o, 0);
    check("rst_last", field_last_o, 0);
    check("rst_app_cnt", app_cnt_o, 0);
    check("rst_all_done", all_done_o, 0);
    check("rst_err", err_o, 0);
    tx_q.delete();
    exp_q.delete();
    held = 1'b0;
    app_exp = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0; rx_i = 1'b0; data_i = '0; eoa_i = 1'b0; field_ready_i = 1'b1;
    rdy_mode = 0; rx_full = 1'b1; mon_en = 1'b1; held = 1'b0; app_exp = '0;
    do_reset();

    // single application, full throughput
    txt_a[0] = 8; dat_a[0] = 4;
    gen_app(2, 1);
    drain();
    check("t1_app_cnt", app_cnt_o, app_exp);
    check("t1_err", err_o, 0);

    // same application under toggling ready
    rdy_mode = 1;
    gen_app(2, 1);
    drain();
    check("bp_app_cnt", app_cnt_o, app_exp);

    // two tasks with truncating bin size, then an app ending on ENTRY
    rdy_mode = 2; rx_full = 1'b0;
    txt_a[0] = 8; dat_a[0] = 4; txt_a[1] = 6; dat_a[1] = 0;
    gen_app(2, 2);
    txt_a[0] = 3; dat_a[0] = 0;
    gen_app(1, 1);
    drain();
    check("two_task_app_cnt", app_cnt_o, app_exp);

    // degenerate app followed by a normal one
    rdy_mode = 2;
    gen_app(0, 0);
    txt_a[0] = 4; dat_a[0] = 4;
    gen_app(1, 1);
    drain();
    check("degen_app_cnt", app_cnt_o, app_exp);
    check("degen_err", err_o, 0);

    // randomized back-to-back applications
    for (int k = 0; k < 10; k++) begin
      for (int t = 0; t < 8; t++) begin
        txt_a[t] = $urandom_range(0, 13);
        dat_a[t] = $urandom_range(0, 13);
      end
      gen_app($urandom_range(0, 3), $urandom_range(0, 3));
    end
    rdy_mode = 2; rx_full = 1'b0;
    drain();
    check("rand_app_cnt", app_cnt_o, app_exp);
    check("rand_err", err_o, 0);

    // reset in the middle of the BIN section
    rdy_mode = 2;
    txt_a[0] = 40; dat_a[0] = 0;
    gen_app(1, 1);
    for (int n = 0; n < 400 && exp_q.size() > 5; n++) cycle();
    field_ready_i = 1'b1;
    do_reset();
    gen_app(0, 0);
    txt_a[0] = 1; dat_a[0] = 3;
    gen_app(0, 1);
    drain();
    check("post_rst_app_cnt", app_cnt_o, app_exp);

    // TAG other than 1
    do_reset();
    mon_en = 1'b0; rdy_mode = 0; rx_full = 1'b1;
    tx_q.push_back(32'd0); tx_q.push_back(32'd1); tx_q.push_back(32'h0101);
    drain();
    check("tag_pre_err", err_o, 0);
    tx_q.push_back(32'd2);
    drain();
    check("tag_err", err_o, 1);

    // task count beyond MAX_TASKS
    do_reset();
    tx_q.push_back(32'd0);
    drain();
    check("tcnt_pre_err", err_o, 0);
    tx_q.push_back(32'd40);
    drain();
    check("tcnt_err", err_o, 1);

    // eoa while in GRAPH
    do_reset();
    tx_q.push_back(32'd2); tx_q.push_back(32'd0); tx_q.push_back(32'hA);
    drain();
    check("graph_pre_err", err_o, 0);
    eoa_i = 1'b1;
    cycle();
    eoa_i = 1'b0;
    check("eoa_graph_err", err_o, 1);
    check("eoa_graph_done", all_done_o, 0);

    // clean end of applications, then a stray flit
    do_reset();
    mon_en = 1'b1;
    gen_app(0, 0);
    drain();
    check("pre_eoa_done", all_done_o, 0);
    eoa_i = 1'b1;
    cycle();
    eoa_i = 1'b0;
    check("eoa_done", all_done_o, 1);
    check("eoa_done_err", err_o, 0);
    check("eoa_app_cnt", app_cnt_o, app_exp);
    tx_q.push_back(32'h55);
    drain();
    check("stray_err", err_o, 1);
    check("stray_valid", field_valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/app_stream_decoder.md
Name: app_stream_decoder

Overview:
- Consumer directly downstream of the application flit source in the task-injection path.
- Accepts the serialized application stream over a tx/credit handshake and tracks protocol position with an FSM: descriptor size, task count, mapping/tag pairs, graph words, then per-task headers and binary words.
- Re-emits every flit one cycle later, tagged with field type, task index and an end-of-application marker, so the injector packetizer never re-parses.
- Raises a sticky error on protocol violations.

Parameters:
- FLIT_SIZE, 32, flit/data width in bits.
- MAX_TASKS, 32, maximum tasks per application. A larger task count sets err_o.
- TASK_IDX_W, 5, width of the task index output, $clog2(MAX_TASKS).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- rx_i  in  1  upstream flit valid.
- credit_o  out  1  ready to upstream. A flit transfers on a rising edge with rx_i && credit_o.
- data_i  in  FLIT_SIZE  upstream flit.
- eoa_i  in  1  upstream end-of-applications level.
- field_valid_o  out  1  decoded field valid.
- field_ready_i  in  1  downstream ready.
- field_type_o  out  4  0 DSIZE, 1 TCNT, 2 MAP, 3 TAG, 4 GRAPH, 5 TEXT, 6 DATA, 7 BSS, 8 ENTRY, 9 BIN.
- field_data_o  out  FLIT_SIZE  flit payload, unmodified.
- task_idx_o  out  TASK_IDX_W  task index for MAP, TAG, TEXT, DATA, BSS, ENTRY and BIN; 0 otherwise.
- field_last_o  out  1  field is the final flit of the current application.
- app_cnt_o  out  16  count of completed applications, wraps at 2^16.
- all_done_o  out  1  sticky, set once all applications are complete.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs are 0 and the FSM is in S_DSIZE. Counters clear. Reset mid-stream abandons the application; the next accepted flit is treated as DSIZE.
- Output stage is a single register.
  - credit_o = !field_valid_o || field_ready_i.
  - An accepted flit appears on field_* on the next cycle (latency 1), held stable until field_ready_i.
  - Full throughput of one flit per cycle when field_ready_i stays high.
- FSM advances only on an accepted flit. Captured values:
  - dsize_q: descriptor size.
  - tcnt_q: task count.
  - bin_q: binary word count.
  - Counters: t_cnt (task), g_cnt (graph), b_cnt (binary).
- State transitions:
  - S_DSIZE: capture dsize_q -> S_TCNT.
  - S_TCNT: capture tcnt_q, clear t_cnt. If tcnt_q > MAX_TASKS, set err_o and clamp the iteration count to MAX_TASKS. If count is 0 -> S_GRAPH; else -> S_MAP.
  - S_MAP -> S_TAG.
  - S_TAG: err_o if the flit is not 1. Increment t_cnt. Go to S_MAP while t_cnt < count, else S_GRAPH.
  - S_GRAPH: consumes dsize_q words. If dsize_q is 0, skip directly to the task phase with no flit consumed in S_GRAPH.
  - Task phase: if count is 0 the application ends after GRAPH. Otherwise t_cnt resets to 0 and each task runs S_TEXT -> S_DATA -> S_BSS -> S_ENTRY -> S_BIN.
  - Binary size: bin_q = (text + data) >> 2, computed in FLIT_SIZE+1 bits, so non-multiple-of-4 sums truncate. S_BIN consumes bin_q words. If bin_q is 0, S_BIN is skipped.
  - After a task, t_cnt increments. Next task -> S_TEXT; otherwise the application ends.
- field_last_o and app_cnt_o:
  - field_last_o is set on the flit that ends the application.
  - Possible last flits: last BIN, ENTRY with bin_q = 0, last GRAPH with tcnt = 0, or TCNT itself when dsize = 0 and tcnt = 0.
  - app_cnt_o increments when that flit is accepted.
  - The FSM then returns to S_DSIZE.
- Tie-offs:
  - task_idx_o is t_cnt[TASK_IDX_W-1:0].
  - Zero-length sections never emit a field.
- eoa_i handling:
  - eoa_i high while in S_DSIZE and field_valid_o low sets all_done_o.
  - eoa_i high in any other state sets err_o.
  - rx_i after all_done_o sets err_o; the flit is accepted and dropped, with no field emitted.
- Simultaneous capture and drain in one cycle: the new flit replaces the old one, and field_valid_o stays high.

Test Plan:
- Single application with DSIZE = 2, TCNT = 1, MAP 0x0101, TAG 1, GRAPH 0xA 0xB, TEXT 8, DATA 4, BSS 0, ENTRY 0x80, BIN 3 words.
  - Expect 13 fields with types 0, 1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 9, 9.
  - task_idx_o = 0 throughout.
  - field_last_o only on the third BIN; app_cnt_o = 1.
- Backpressure: field_ready_i toggles every other cycle.
  - credit_o deasserts while output is held.
  - No flit is lost or duplicated; data order is identical.
- Two tasks where task 1 has TEXT 6, DATA 0, giving bin_q = 1 (truncation).
  - Task 1 BIN emitted once with task_idx_o = 1.
  - An ENTRY with bin_q = 0 sets field_last_o on ENTRY.
- Degenerate application with DSIZE = 0, TCNT = 0.
  - field_last_o is set on TCNT and app_cnt_o increments.
  - The next flit decodes as DSIZE.
- Errors, each checked independently:
  - TAG = 2 sets err_o.
  - TCNT = 40 with MAX_TASKS = 32 sets err_o.
  - eoa_i asserted in S_GRAPH sets err_o.
  - Clean eoa_i in S_DSIZE sets all_done_o with err_o = 0.
- Reset: assert rst_ni low mid-BIN.
  - All outputs are 0 during reset.
  - After release, the first flit decodes as type 0.
